mole_timer: RTL and testbench

Interval timer driven by `mole_control_fsm`: it consumes that FSM's `reset`, `up` and `enable` outputs and produces the `timer_value` the FSM compares against 0. It divides the system clock into fixed ticks with a prescaler and counts an 11-bit value down from a loaded interval, or up from zero, once per tick. It saturates at the end of range, flags expiry, and emits a tick strobe for display or scoring logic.

---
 rtl/mole_timer.sv | 76 +++++++
 tb/tb_mole_timer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_timer.sv
// Prescaled 11-bit interval timer for the mole control FSM: counts down from a
// loaded interval or up from zero, saturating at the end of range.
// Optional feature: define MOLE_TIMER_AUTOSTOP_EN to freeze the prescaler once expired.
module mole_timer #(
  parameter int WIDTH         = 11,
  parameter int CLKS_PER_TICK = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             timer_reset,
  input  logic             up,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] timer_value,
  output logic             tick,
  output logic             expired
);

  localparam int               PRE_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_TICK - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

  logic [PRE_W-1:0] pre;
  logic             dir;
  logic             run;
  logic             wrap;

  // One count step in the latched direction, clamped at either end of range.
  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] v, input logic d);
    logic [WIDTH-1:0] r;
    r = v;
    if (d) begin
      if (v != MAX_VAL) r = v + WIDTH'(1);
    end else begin
      if (v != '0) r = v - WIDTH'(1);
    end
    return r;
  endfunction

  // Decoded from registers only, so there is no input-to-output path.
  assign expired = dir ? (timer_value == MAX_VAL) : (timer_value == '0);
  assign wrap    = (pre == PRE_LAST);

`ifdef MOLE_TIMER_AUTOSTOP_EN
  assign run = enable & ~expired;
`else
  assign run = enable;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_value <= MAX_VAL;
      pre         <= '0;
      dir         <= 1'b0;
      tick        <= 1'b0;
    end else if (timer_reset) begin
      // A load beats a simultaneous prescaler wrap: no step, no tick.
      dir         <= up;
      timer_value <= up ? '0 : load_value;
      pre         <= '0;
      tick        <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        pre         <= '0;
        tick        <= 1'b1;
        timer_value <= sat_step(timer_value, dir);
      end else begin
        pre  <= pre + PRE_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mole_timer.sv
// Self-checking bench for mole_timer: two instances (4 and 1 clocks per tick)
// share stimulus and are checked against an enabled-cycle-count reference model.
module tb_mole_timer;

  localparam int MAXV = 2047;
`ifdef MOLE_TIMER_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        timer_reset = 1'b0;
  logic        up = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] load_value = '0;
  logic [10:0] v4, v1;
  logic        t4, t1, e4, e1;

  int tests = 0;
  int fails = 0;

  // Model: value is derived from the loaded base and the number of counted
  // cycles since the load; reset behaves like a down-load of MAX.
  int   mbase[2];
  int   md[2];
  int   mn[2];
  logic mtk[2];
  int   cpt[2] = '{4, 1};

  mole_timer #(.WIDTH(11), .CLKS_PER_TICK(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .timer_reset(timer_reset), .up(up),
    .enable(enable), .load_value(load_value),
    .timer_value(v4), .tick(t4), .expired(e4));

  mole_timer #(.WIDTH(11), .CLKS_PER_TICK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .timer_reset(timer_reset), .up(up),
    .enable(enable), .load_value(load_value),
    .timer_value(v1), .tick(t1), .expired(e1));

  always #5 clk = ~clk;

  function automatic int mval(int i);
    int v;
    if (md[i] == 0) begin
      v = mbase[i] - mn[i] / cpt[i];
      if (v < 0) v = 0;
    end else begin
      v = mn[i] / cpt[i];
      if (v > MAXV) v = MAXV;
    end
    return v;
  endfunction

  function automatic logic mexp(int i);
    return (md[i] == 0) ? (mval(i) == 0) : (mval(i) == MAXV);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mbase[i] = MAXV; md[i] = 0; mn[i] = 0; mtk[i] = 1'b0;
    end
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // and return 1 time unit later so outputs can be sampled off the edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mbase[i] = MAXV; md[i] = 0; mn[i] = 0; mtk[i] = 1'b0;
      end else if (timer_reset) begin
        mbase[i] = up ? 0 : int'(load_value);
        md[i] = up ? 1 : 0; mn[i] = 0; mtk[i] = 1'b0;
      end else if (enable && !(AUTOSTOP && mexp(i))) begin
        mn[i]++;
        mtk[i] = ((mn[i] % cpt[i]) == 0);
      end else begin
        mtk[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic load(input logic dir_up, input int val);
    up = dir_up; load_value = 11'(val); timer_reset = 1'b1;
    step();
    timer_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    model_reset();
    step(); step();
    tests++;
    if (v4 !== 11'd2047 || t4 !== 1'b0 || e4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: value=%0d tick=%b expired=%b, want 2047 0 0", v4, t4, e4);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++;
      if (v4 !== 11'd2047 || t4 !== 1'b0 || e4 !== 1'b0 || v1 !== 11'd2047 || t1 !== 1'b0 || e1 !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: v4=%0d t4=%b e4=%b v1=%0d t1=%b e1=%b, want 2047 0 0",
                 c, v4, t4, e4, v1, t1, e1);
      end
    end
  endtask

  task automatic test_countdown();
    enable = 1'b0;
    load(1'b0, 5);
    tests++;
    if (v4 !== 11'd5 || e4 !== 1'b0 || t4 !== 1'b0) begin
      fails++;
      $display("FAIL countdown_load: value=%0d expired=%b tick=%b, want 5 0 0", v4, e4, t4);
    end
    enable = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      tests++;
      if (v4 !== 11'(mval(0)) || t4 !== mtk[0] || e4 !== mexp(0) ||
          v1 !== 11'(mval(1)) || t1 !== mtk[1] || e1 !== mexp(1)) begin
        fails++;
        $display("FAIL countdown cyc %0d: v4=%0d t4=%b e4=%b v1=%0d t1=%b e1=%b, want %0d %b %b %0d %b %b",
                 c, v4, t4, e4, v1, t1, e1, mval(0), mtk[0], mexp(0), mval(1), mtk[1], mexp(1));
      end
      if (c <= 20) begin
        tests++;
        if (t4 !== ((c % 4) == 0) || v4 !== 11'(5 - c / 4)) begin
          fails++;
          $display("FAIL countdown_seq cyc %0d: value=%0d tick=%b, want %0d %b", c, v4, t4, 5 - c / 4, (c % 4) == 0);
        end
      end
      if (c == 19 || c == 20) begin
        tests++;
        if (e4 !== (c == 20)) begin
          fails++;
          $display("FAIL countdown_expiry cyc %0d: expired=%b, want %b", c, e4, c == 20);
        end
      end
    end
    tests++;
    if (v4 !== 11'd0) begin
      fails++;
      $display("FAIL countdown_floor: value=%0d, want 0", v4);
    end
  endtask

  task automatic test_saturate_up();
    enable = 1'b0;
    load(1'b1, 0);
    enable = 1'b1;
    for (int c = 1; c <= 2047; c++) begin
      step();
      if (c == 2046) begin
        tests++;
        if (v1 !== 11'd2046 || e1 !== 1'b0) begin
          fails++;
          $display("FAIL up_2046: value=%0d expired=%b, want 2046 0", v1, e1);
        end
      end
    end
    tests++;
    if (v1 !== 11'd2047 || e1 !== 1'b1) begin
      fails++;
      $display("FAIL up_max: value=%0d expired=%b, want 2047 1", v1, e1);
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      tests++;
      if (v1 !== 11'd2047 || e1 !== 1'b1 || t1 !== mtk[1]) begin
        fails++;
        $display("FAIL up_saturated cyc %0d: value=%0d expired=%b tick=%b, want 2047 1 %b", c, v1, e1, t1, mtk[1]);
      end
    end
    tests++;
    if (v4 !== 11'(mval(0)) || e4 !== mexp(0)) begin
      fails++;
      $display("FAIL up_slow: value=%0d expired=%b, want %0d %b", v4, e4, mval(0), mexp(0));
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    load(1'b0, 5);
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    for (int c = 0; c < 10; c++) step();
    tests++;
    if (v4 !== 11'd5 || t4 !== 1'b0) begin
      fails++;
      $display("FAIL hold_value: value=%0d tick=%b, want 5 0", v4, t4);
    end
    enable = 1'b1;
    step();
    tests++;
    if (v4 !== 11'd5 || t4 !== 1'b0) begin
      fails++;
      $display("FAIL hold_resume1: value=%0d tick=%b, want 5 0", v4, t4);
    end
    step();
    tests++;
    if (v4 !== 11'd4 || t4 !== 1'b1) begin
      fails++;
      $display("FAIL hold_resume2: value=%0d tick=%b, want 4 1", v4, t4);
    end
  endtask

  task automatic test_load_wrap();
    enable = 1'b0;
    load(1'b0, 5);
    enable = 1'b1;
    step(); step(); step();
    load(1'b0, 9);
    tests++;
    if (v4 !== 11'd9 || t4 !== 1'b0 || e4 !== 1'b0 || v1 !== 11'd9 || t1 !== 1'b0) begin
      fails++;
      $display("FAIL load_on_wrap: v4=%0d t4=%b e4=%b v1=%0d t1=%b, want 9 0 0 9 0", v4, t4, e4, v1, t1);
    end
    step(); step(); step(); step();
    tests++;
    if (v4 !== 11'd8 || t4 !== 1'b1) begin
      fails++;
      $display("FAIL load_then_step: value=%0d tick=%b, want 8 1", v4, t4);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b0;
    load(1'b0, 100);
    enable = 1'b1;
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (v4 !== 11'd99 || t4 !== 1'b1) begin
      fails++;
      $display("FAIL pre_async: value=%0d tick=%b, want 99 1", v4, t4);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (v4 !== 11'd2047 || t4 !== 1'b0 || e4 !== 1'b0 || v1 !== 11'd2047 || t1 !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: v4=%0d t4=%b e4=%b v1=%0d t1=%b, want 2047 0 0 2047 0", v4, t4, e4, v1, t1);
    end
    model_reset();
    step();
    reset_n = 1'b1;
    enable = 1'b0;
    step();
    tests++;
    if (v4 !== 11'(mval(0)) || t4 !== mtk[0] || v1 !== 11'(mval(1)) || t1 !== mtk[1]) begin
      fails++;
      $display("FAIL post_async: v4=%0d t4=%b v1=%0d t1=%b, want %0d %b %0d %b", v4, t4, v1, t1, mval(0), mtk[0], mval(1), mtk[1]);
    end
  endtask

  task automatic test_expired_ticks();
    int n4;
    int n1;
    enable = 1'b0;
    load(1'b0, 2);
    enable = 1'b1;
    for (int c = 0; c < 8; c++) step();
    tests++;
    if (e4 !== 1'b1 || v4 !== 11'd0) begin
      fails++;
      $display("FAIL expire_down: value=%0d expired=%b, want 0 1", v4, e4);
    end
    n4 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      n4 += int'(t4);
      n1 += int'(t1);
    end
    tests++;
    if (n4 != (AUTOSTOP ? 0 : 3) || v4 !== 11'd0) begin
      fails++;
      $display("FAIL expired_ticks c4: ticks=%0d value=%0d, want %0d 0", n4, v4, AUTOSTOP ? 0 : 3);
    end
    tests++;
    if (n1 != (AUTOSTOP ? 0 : 12) || v1 !== 11'd0) begin
      fails++;
      $display("FAIL expired_ticks c1: ticks=%0d value=%0d, want %0d 0", n1, v1, AUTOSTOP ? 0 : 12);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      timer_reset = ($urandom_range(0, 31) == 0);
      up          = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 3) != 0);
      load_value  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 12));
      step();
      tests++;
      if (v4 !== 11'(mval(0)) || t4 !== mtk[0] || e4 !== mexp(0) ||
          v1 !== 11'(mval(1)) || t1 !== mtk[1] || e1 !== mexp(1)) begin
        fails++;
        $display("FAIL random cyc %0d: v4=%0d t4=%b e4=%b v1=%0d t1=%b e1=%b, want %0d %b %b %0d %b %b",
                 c, v4, t4, e4, v1, t1, e1, mval(0), mtk[0], mexp(0), mval(1), mtk[1], mexp(1));
      end
    end
    timer_reset = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_saturate_up();
    test_hold();
    test_load_wrap();
    test_async_reset();
    test_expired_ticks();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
